mont_conv: RTL and testbench



---
 rtl/ntt_pkg.sv | 28 ++
 rtl/mont_conv_step.sv | 27 ++
 rtl/mont_conv.sv | 89 ++++++++
 tb/tb_mont_conv.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared NTT constants and types: modulus, Montgomery constants, converter FSM states.
package ntt_pkg;

  localparam int Q_K        = 13;
  localparam int Q_M        = 8;
  localparam int Q          = Q_K * (2 ** Q_M) + 1;
  localparam int DATA_WIDTH = 12;

  // 2^(2*width) mod q by repeated doubling, so no wide intermediate is needed.
  function automatic int mont_r2(input int q, input int width);
    longint r;
    r = 1;
    for (int i = 0; i < 2 * width; i++) begin
      r = (r * 2) % longint'(q);
    end
    return int'(r);
  endfunction

  localparam int MONT_R2 = mont_r2(Q, DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } mont_conv_state_e;

endpackage

// File: rtl/mont_conv_step.sv
// One radix-2 Montgomery iteration: next_s = (s + b*a [+ Q if odd]) / 2.
module mont_conv_step
  import ntt_pkg::*;
#(
  parameter int DATA_WIDTH = ntt_pkg::DATA_WIDTH
) (
  input  logic [DATA_WIDTH+1:0] s,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic                  b,
  output logic [DATA_WIDTH+1:0] s_next
);

  localparam int SW = DATA_WIDTH + 2;
  localparam logic [SW-1:0] Q_S = SW'(Q);

  logic [SW-1:0] t;

  // NOTE: blocking assignments inside always_comb, with every target given a value first, keep this purely combinational with no latch.
  always_comb begin
    t = s + (b ? {2'b00, a} : '0);
    if (t[0]) begin
      t = t + Q_S;
    end
    s_next = {1'b0, t[SW-1:1]};
  end

endmodule

// File: rtl/mont_conv.sv
// Bit-serial Montgomery domain converter: x*R mod Q (to) or x*R^-1 mod Q (from), R = 2^WIDTH.
module mont_conv
  import ntt_pkg::*;
#(
  parameter int DATA_WIDTH = ntt_pkg::DATA_WIDTH,
  parameter int WIDTH      = DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_to_mont,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SW = DATA_WIDTH + 2;
  localparam logic [SW-1:0]    Q_S  = SW'(Q);
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] R2   =
    WIDTH'((WIDTH == DATA_WIDTH) ? MONT_R2 : mont_r2(Q, WIDTH));

  mont_conv_state_e      state;
  logic [DATA_WIDTH-1:0] a;
  logic [WIDTH-1:0]      b;
  logic [SW-1:0]         s;
  logic [SW-1:0]         s_next;
  logic [CW-1:0]         cnt;

  mont_conv_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .s     (s),
    .a     (a),
    .b     (b[cnt]),
    .s_next(s_next)
  );

  assign in_ready = (state == IDLE);

  // NOTE: reset is synchronous, so it lives inside the clocked block; all state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a         <= '0;
      b         <= '0;
      s         <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a     <= in_data;
            b     <= in_to_mont ? R2 : WIDTH'(1);
            s     <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          s   <= s_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          // S < 2Q, so a single conditional subtract fully reduces.
          out_data  <= (s >= Q_S) ? DATA_WIDTH'(s - Q_S) : DATA_WIDTH'(s);
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_conv.sv
// Self-checking bench for mont_conv (Kyber: Q=3329, 12-bit) with an arithmetic reference model.
module tb_mont_conv;

  localparam int DW    = 12;
  localparam int WIDTH = 12;
  localparam int QM    = 3329;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_to_mont;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  logic [DW+1:0] step_s;
  logic [DW-1:0] step_a;
  logic          step_b;
  logic [DW+1:0] step_next;

  int n_checks = 0;
  int n_fail   = 0;
  longint r_inv;
  longint r2_model;

  always #5 clk = ~clk;

  mont_conv #(
    .DATA_WIDTH(DW),
    .WIDTH     (WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_to_mont(in_to_mont),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  mont_conv_step #(
    .DATA_WIDTH(DW)
  ) u_step (
    .s     (step_s),
    .a     (step_a),
    .b     (step_b),
    .s_next(step_next)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: result = x * B * R^-1 mod Q, with B = R^2 mod Q (to) or 1 (from).
  function automatic int model(input int x, input bit to);
    longint bb;
    bb = to ? r2_model : 64'd1;
    return int'(((longint'(x) * bb) % QM) * r_inv % QM);
  endfunction

  task automatic convert(input int x, input bit to, input bit stall, output int res);
    bit got;
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    in_valid   = 1'b1;
    in_data    = DW'(x);
    in_to_mont = to;
    @(negedge clk);
    in_valid = 1'b0;
    got = 1'b0;
    res = -1;
    for (int i = 0; i < 200 && !got; i++) begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        res = int'(out_data);
        got = 1'b1;
      end
      @(negedge clk);
    end
    check("out_handshake", 32'(got), 32'd1);
  endtask

  initial begin
    int res, res2, x, n, exp_s;
    bit to, seen;
    int dir_x[5]  = '{767, 3328, 2562, 0, 0};
    bit dir_to[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int dir_e[5]  = '{1, 2562, 3328, 0, 0};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_to_mont = 1'b0; out_ready = 1'b0;
    step_s = '0; step_a = '0; step_b = 1'b0;

    r2_model = 1;
    for (int i = 0; i < 2 * WIDTH; i++) r2_model = (r2_model * 2) % QM;
    r_inv = 0;
    for (longint r = 1; r < QM; r++) begin
      if (((longint'(1) << WIDTH) * r) % QM == 1) r_inv = r;
    end

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);

    // Single-iteration unit: directed vector, then random ones within S < 2Q, A < Q.
    step_s = '0; step_a = 12'd1; step_b = 1'b1;
    #1 check("step_basic", 32'(step_next), 32'd1665);
    for (int i = 0; i < 8; i++) begin
      step_s = (DW+2)'($urandom_range(0, 2 * QM - 1));
      step_a = DW'($urandom_range(0, QM - 1));
      step_b = 1'($urandom_range(0, 1));
      exp_s = int'(step_s) + (step_b ? int'(step_a) : 0);
      if (exp_s % 2 == 1) exp_s = exp_s + QM;
      exp_s = exp_s / 2;
      #1 check("step_random", 32'(step_next), 32'(exp_s));
    end

    // Latency: accept at edge k, out_valid visible after edge k+WIDTH+1.
    @(negedge clk);
    in_valid = 1'b1; in_data = 12'd1; in_to_mont = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("lat_in_ready_accept", 32'(in_ready), 32'd0);
    for (int e = 1; e <= WIDTH; e++) begin
      @(negedge clk);
      check("lat_out_valid_early", 32'(out_valid), 32'd0);
      check("lat_in_ready_busy", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    check("lat_out_valid", 32'(out_valid), 32'd1);
    check("lat_out_data", 32'(out_data), 32'd767);
    check("lat_in_ready_done", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("lat_out_valid_after", 32'(out_valid), 32'd0);
    check("lat_in_ready_after", 32'(in_ready), 32'd1);

    for (int i = 0; i < 5; i++) begin
      convert(dir_x[i], dir_to[i], 1'b0, res);
      check("directed", 32'(res), 32'(dir_e[i]));
      check("directed_model", 32'(res), 32'(model(dir_x[i], dir_to[i])));
    end

    // Backpressure: result held, in_ready low, a stray in_valid is ignored.
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 12'd1; in_to_mont = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid", 32'(out_valid), 32'd1);
    for (int c = 0; c < 6; c++) begin
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_data", 32'(out_data), 32'd767);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      if (c == 2) begin
        in_valid = 1'b1; in_data = 12'd5; in_to_mont = 1'b0;
      end
      if (c == 3) in_valid = 1'b0;
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int c = 0; c < WIDTH + 4; c++) begin
      @(negedge clk);
      if (out_valid || !in_ready) seen = 1'b1;
    end
    check("bp_stray_ignored", 32'(seen), 32'd0);

    // Reset in the middle of RUN discards the word.
    @(negedge clk);
    in_valid = 1'b1; in_data = 12'd1; in_to_mont = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    check("rst_mid_out_data", 32'(out_data), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < WIDTH + 4; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("rst_mid_no_output", 32'(seen), 32'd0);
    convert(767, 1'b0, 1'b0, res);
    check("rst_mid_next_word", 32'(res), 32'd1);

    // Random round trips with output stalls.
    for (int i = 0; i < 700; i++) begin
      x = int'($urandom_range(0, QM - 1));
      to = 1'b1;
      convert(x, to, 1'b1, res);
      check("rt_to", 32'(res), 32'(model(x, to)));
      check("rt_to_range", 32'(res < QM), 32'd1);
      convert(res, 1'b0, 1'b1, res2);
      check("rt_back", 32'(res2), 32'(x));
      check("rt_back_range", 32'(res2 < QM), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
